// File: rtl/issue_stall_ctrl.sv
// issue_stall_ctrl: classifies the fetched instruction, allocates the lowest
// free entry in the ALU station or the LS buffer, registers an issue packet
// with its entry tag, raises A_stall/LS_stall when the target is full, and
// recycles entries on release.
// Ports:
//   clk, reset (async active-low)
//   instr                       fetched instruction
//   a_release/a_release_tag     ALU entry free request
//   ls_release/ls_release_tag   LS entry free request
//   A_stall, LS_stall           combinational PC hold requests
//   issue_valid/is_ls/instr/tag registered issue packet
//   a_count, ls_count           busy entries per station
module issue_stall_ctrl #(
    parameter int unsigned A_DEPTH  = 4,
    parameter int unsigned LS_DEPTH = 4,
    parameter int unsigned A_TW     = $clog2(A_DEPTH),
    parameter int unsigned LS_TW    = $clog2(LS_DEPTH)
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [31:0]                                 instr,
    input  logic                                        a_release,
    input  logic [A_TW-1:0]                             a_release_tag,
    input  logic                                        ls_release,
    input  logic [LS_TW-1:0]                            ls_release_tag,
    output logic                                        A_stall,
    output logic                                        LS_stall,
    output logic                                        issue_valid,
    output logic                                        issue_is_ls,
    output logic [31:0]                                 issue_instr,
    output logic [((A_TW > LS_TW) ? A_TW : LS_TW)-1:0]  issue_tag,
    output logic [$clog2(A_DEPTH+1)-1:0]                a_count,
    output logic [$clog2(LS_DEPTH+1)-1:0]               ls_count
);

    localparam int unsigned TAG_W = (A_TW > LS_TW) ? A_TW : LS_TW;
    localparam int unsigned A_CW  = $clog2(A_DEPTH + 1);
    localparam int unsigned LS_CW = $clog2(LS_DEPTH + 1);

    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    logic [A_DEPTH-1:0]  a_busy_q, a_busy_d;
    logic [LS_DEPTH-1:0] ls_busy_q, ls_busy_d;
    logic [A_CW-1:0]     a_count_q, a_count_d;
    logic [LS_CW-1:0]    ls_count_q, ls_count_d;
    logic                issue_valid_q;
    logic                issue_is_ls_q;
    logic [31:0]         issue_instr_q;
    logic [TAG_W-1:0]    issue_tag_q;

    logic [6:0]          opcode_c;
    logic                is_alu_c, is_ls_c;
    logic                a_full_c, ls_full_c;
    logic                a_alloc_c, ls_alloc_c;
    logic [A_TW-1:0]     a_idx_c;
    logic [LS_TW-1:0]    ls_idx_c;

    // Decode and stall: depends only on instr and registered busy masks
    always_comb begin
        opcode_c   = instr[6:0];
        is_alu_c   = (opcode_c == OP_REG) || (opcode_c == OP_IMM) ||
                     (opcode_c == OP_LUI) || (opcode_c == OP_AUIPC);
        is_ls_c    = (opcode_c == OP_LOAD) || (opcode_c == OP_STORE);
        a_full_c   = &a_busy_q;
        ls_full_c  = &ls_busy_q;
        a_alloc_c  = is_alu_c && !a_full_c;
        ls_alloc_c = is_ls_c && !ls_full_c;
    end

    assign A_stall  = is_alu_c && a_full_c;
    assign LS_stall = is_ls_c && ls_full_c;

    // Lowest free index; scanning downward leaves the smallest one last
    always_comb begin
        a_idx_c = '0;
        for (int i = int'(A_DEPTH) - 1; i >= 0; i--) begin
            if (!a_busy_q[i]) a_idx_c = A_TW'(i);
        end
        ls_idx_c = '0;
        for (int i = int'(LS_DEPTH) - 1; i >= 0; i--) begin
            if (!ls_busy_q[i]) ls_idx_c = LS_TW'(i);
        end
    end

    // Next busy masks: release clears, allocation sets; out-of-range tags match no bit
    always_comb begin
        a_busy_d  = a_busy_q;
        ls_busy_d = ls_busy_q;
        for (int i = 0; i < int'(A_DEPTH); i++) begin
            if (a_release && (a_release_tag == A_TW'(i))) a_busy_d[i] = 1'b0;
            if (a_alloc_c && (a_idx_c == A_TW'(i)))       a_busy_d[i] = 1'b1;
        end
        for (int i = 0; i < int'(LS_DEPTH); i++) begin
            if (ls_release && (ls_release_tag == LS_TW'(i))) ls_busy_d[i] = 1'b0;
            if (ls_alloc_c && (ls_idx_c == LS_TW'(i)))       ls_busy_d[i] = 1'b1;
        end
    end

    // Popcounts of the next masks, registered alongside them
    always_comb begin
        a_count_d = '0;
        for (int i = 0; i < int'(A_DEPTH); i++) begin
            a_count_d = a_count_d + A_CW'(a_busy_d[i]);
        end
        ls_count_d = '0;
        for (int i = 0; i < int'(LS_DEPTH); i++) begin
            ls_count_d = ls_count_d + LS_CW'(ls_busy_d[i]);
        end
    end

    // State and issue packet registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_busy_q      <= '0;
            ls_busy_q     <= '0;
            a_count_q     <= '0;
            ls_count_q    <= '0;
            issue_valid_q <= 1'b0;
            issue_is_ls_q <= 1'b0;
            issue_instr_q <= '0;
            issue_tag_q   <= '0;
        end else begin
            a_busy_q      <= a_busy_d;
            ls_busy_q     <= ls_busy_d;
            a_count_q     <= a_count_d;
            ls_count_q    <= ls_count_d;
            issue_valid_q <= a_alloc_c || ls_alloc_c;
            if (a_alloc_c) begin
                issue_instr_q <= instr;
                issue_is_ls_q <= 1'b0;
                issue_tag_q   <= TAG_W'(a_idx_c);
            end else if (ls_alloc_c) begin
                issue_instr_q <= instr;
                issue_is_ls_q <= 1'b1;
                issue_tag_q   <= TAG_W'(ls_idx_c);
            end
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_is_ls = issue_is_ls_q;
    assign issue_instr = issue_instr_q;
    assign issue_tag   = issue_tag_q;
    assign a_count     = a_count_q;
    assign ls_count    = ls_count_q;

endmodule

// File: tb/tb_issue_stall_ctrl.sv
module tb_issue_stall_ctrl;

    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] LW   = 32'h0000A103;
    localparam logic [31:0] JAL  = 32'h0000006F;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        a_release;
    logic [1:0]  a_release_tag;
    logic        ls_release;
    logic [1:0]  ls_release_tag;
    logic        A_stall, LS_stall;
    logic        issue_valid, issue_is_ls;
    logic [31:0] issue_instr;
    logic [1:0]  issue_tag;
    logic [2:0]  a_count, ls_count;

    int checks = 0;
    int errors = 0;

    issue_stall_ctrl #(.A_DEPTH(4), .LS_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .instr(instr),
        .a_release(a_release), .a_release_tag(a_release_tag),
        .ls_release(ls_release), .ls_release_tag(ls_release_tag),
        .A_stall(A_stall), .LS_stall(LS_stall),
        .issue_valid(issue_valid), .issue_is_ls(issue_is_ls),
        .issue_instr(issue_instr), .issue_tag(issue_tag),
        .a_count(a_count), .ls_count(ls_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        a_release = 1'b0; a_release_tag = '0;
        ls_release = 1'b0; ls_release_tag = '0;
        step(); step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        instr = ADDI;
        do_reset();
        reset = 1'b0;
        step();
        checks++;
        if ({A_stall, LS_stall, issue_valid, issue_is_ls} !== 4'b0) begin
            errors++; $display("FAIL rst_flags got %b exp 0000", {A_stall, LS_stall, issue_valid, issue_is_ls});
        end
        checks++;
        if ({issue_instr, issue_tag, a_count, ls_count} !== 40'd0) begin
            errors++; $display("FAIL rst_fields got instr=%h tag=%0d ac=%0d lc=%0d exp all 0", issue_instr, issue_tag, a_count, ls_count);
        end
        reset = 1'b1;
        step();
        checks++;
        if (issue_valid !== 1'b1 || issue_is_ls !== 1'b0 || issue_tag !== 2'd0 || a_count !== 3'd1 || issue_instr !== ADDI) begin
            errors++; $display("FAIL rst_first_issue got v=%b ls=%b tag=%0d ac=%0d instr=%h exp 1 0 0 1 %h", issue_valid, issue_is_ls, issue_tag, a_count, issue_instr, ADDI);
        end
    endtask

    task automatic test_alu_fill();
        instr = ADDI;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (issue_valid !== 1'b1 || issue_tag !== 2'(k) || a_count !== 3'(k + 1)) begin
                errors++; $display("FAIL fill_%0d got v=%b tag=%0d ac=%0d exp 1 %0d %0d", k, issue_valid, issue_tag, a_count, k, k + 1);
            end
        end
        checks++;
        if (A_stall !== 1'b1 || LS_stall !== 1'b0) begin
            errors++; $display("FAIL fill_stall got A=%b LS=%b exp 1 0", A_stall, LS_stall);
        end
        step();
        checks++;
        if (issue_valid !== 1'b0 || a_count !== 3'd4 || issue_tag !== 2'd3 || A_stall !== 1'b1) begin
            errors++; $display("FAIL fill_fifth got v=%b ac=%0d tag=%0d A=%b exp 0 4 3 1", issue_valid, a_count, issue_tag, A_stall);
        end
    endtask

    task automatic test_ls_independence();
        instr = LW;
        #1;
        checks++;
        if (LS_stall !== 1'b0 || A_stall !== 1'b0) begin
            errors++; $display("FAIL ls_ind_stall got A=%b LS=%b exp 0 0", A_stall, LS_stall);
        end
        step();
        checks++;
        if (issue_valid !== 1'b1 || issue_is_ls !== 1'b1 || issue_tag !== 2'd0 || ls_count !== 3'd1 || a_count !== 3'd4 || issue_instr !== LW) begin
            errors++; $display("FAIL ls_ind got v=%b ls=%b tag=%0d lc=%0d ac=%0d instr=%h exp 1 1 0 1 4 %h", issue_valid, issue_is_ls, issue_tag, ls_count, a_count, issue_instr, LW);
        end
    endtask

    task automatic test_release_resume();
        instr = ADDI;
        a_release = 1'b1; a_release_tag = 2'd2;
        #1;
        checks++;
        if (A_stall !== 1'b1) begin
            errors++; $display("FAIL rel_no_comb_path got A=%b exp 1", A_stall);
        end
        step();
        a_release = 1'b0;
        checks++;
        if (A_stall !== 1'b0 || issue_valid !== 1'b0 || a_count !== 3'd3) begin
            errors++; $display("FAIL rel_next got A=%b v=%b ac=%0d exp 0 0 3", A_stall, issue_valid, a_count);
        end
        step();
        checks++;
        if (issue_valid !== 1'b1 || issue_tag !== 2'd2 || issue_is_ls !== 1'b0 || a_count !== 3'd4 || A_stall !== 1'b1) begin
            errors++; $display("FAIL rel_resume got v=%b tag=%0d ls=%b ac=%0d A=%b exp 1 2 0 4 1", issue_valid, issue_tag, issue_is_ls, a_count, A_stall);
        end
    endtask

    task automatic test_simul_alloc_release();
        // Free entries 3 then 2 under bubbles to reach busy = 0011
        instr = JAL;
        a_release = 1'b1; a_release_tag = 2'd3;
        step();
        a_release_tag = 2'd2;
        step();
        a_release = 1'b0;
        checks++;
        if (a_count !== 3'd2 || issue_valid !== 1'b0) begin
            errors++; $display("FAIL sim_setup got ac=%0d v=%b exp 2 0", a_count, issue_valid);
        end
        instr = ADDI;
        a_release = 1'b1; a_release_tag = 2'd0;
        step();
        a_release = 1'b0;
        checks++;
        if (issue_valid !== 1'b1 || issue_tag !== 2'd2 || a_count !== 3'd2) begin
            errors++; $display("FAIL sim_alloc got v=%b tag=%0d ac=%0d exp 1 2 2", issue_valid, issue_tag, a_count);
        end
        // busy = 0110 implies the next two allocations are 0 then 3
        step();
        checks++;
        if (issue_tag !== 2'd0 || a_count !== 3'd3) begin
            errors++; $display("FAIL sim_next0 got tag=%0d ac=%0d exp 0 3", issue_tag, a_count);
        end
        step();
        checks++;
        if (issue_tag !== 2'd3 || a_count !== 3'd4 || A_stall !== 1'b1) begin
            errors++; $display("FAIL sim_next3 got tag=%0d ac=%0d A=%b exp 3 4 1", issue_tag, a_count, A_stall);
        end
    endtask

    task automatic test_bubble_invalid_release();
        instr = JAL;
        ls_release = 1'b1; ls_release_tag = 2'd3;
        #1;
        checks++;
        if (A_stall !== 1'b0 || LS_stall !== 1'b0) begin
            errors++; $display("FAIL bub_stall got A=%b LS=%b exp 0 0", A_stall, LS_stall);
        end
        step();
        ls_release = 1'b0;
        checks++;
        if (issue_valid !== 1'b0 || a_count !== 3'd4 || ls_count !== 3'd1 || issue_tag !== 2'd3 || issue_instr !== ADDI) begin
            errors++; $display("FAIL bub got v=%b ac=%0d lc=%0d tag=%0d instr=%h exp 0 4 1 3 %h", issue_valid, a_count, ls_count, issue_tag, issue_instr, ADDI);
        end
    endtask

    task automatic test_ls_back_to_back();
        instr = LW;
        for (int k = 1; k < 4; k++) begin
            step();
            checks++;
            if (issue_valid !== 1'b1 || issue_is_ls !== 1'b1 || issue_tag !== 2'(k) || ls_count !== 3'(k + 1)) begin
                errors++; $display("FAIL ls_b2b_%0d got v=%b ls=%b tag=%0d lc=%0d exp 1 1 %0d %0d", k, issue_valid, issue_is_ls, issue_tag, ls_count, k, k + 1);
            end
        end
        checks++;
        if (LS_stall !== 1'b1 || A_stall !== 1'b0) begin
            errors++; $display("FAIL ls_full_stall got A=%b LS=%b exp 0 1", A_stall, LS_stall);
        end
        ls_release = 1'b1; ls_release_tag = 2'd1;
        step();
        ls_release = 1'b0;
        checks++;
        if (LS_stall !== 1'b0 || issue_valid !== 1'b0 || ls_count !== 3'd3) begin
            errors++; $display("FAIL ls_rel got LS=%b v=%b lc=%0d exp 0 0 3", LS_stall, issue_valid, ls_count);
        end
        step();
        checks++;
        if (issue_valid !== 1'b1 || issue_tag !== 2'd1 || ls_count !== 3'd4) begin
            errors++; $display("FAIL ls_resume got v=%b tag=%0d lc=%0d exp 1 1 4", issue_valid, issue_tag, ls_count);
        end
    endtask

    task automatic test_mid_reset();
        instr = ADDI;
        #2;
        reset = 1'b0;
        a_release = 1'b1; a_release_tag = 2'd1;
        #1;
        checks++;
        if (a_count !== 3'd0 || ls_count !== 3'd0 || issue_valid !== 1'b0 || A_stall !== 1'b0 || LS_stall !== 1'b0 || issue_tag !== 2'd0) begin
            errors++; $display("FAIL mid_rst got ac=%0d lc=%0d v=%b A=%b LS=%b tag=%0d exp all 0", a_count, ls_count, issue_valid, A_stall, LS_stall, issue_tag);
        end
        step();
        a_release = 1'b0;
        reset = 1'b1;
        step();
        checks++;
        if (issue_valid !== 1'b1 || issue_tag !== 2'd0 || a_count !== 3'd1 || ls_count !== 3'd0) begin
            errors++; $display("FAIL mid_rst_issue got v=%b tag=%0d ac=%0d lc=%0d exp 1 0 1 0", issue_valid, issue_tag, a_count, ls_count);
        end
    endtask

    initial begin
        reset = 1'b0;
        instr = '0;
        a_release = 1'b0; a_release_tag = '0;
        ls_release = 1'b0; ls_release_tag = '0;
        test_reset();
        test_alu_fill();
        test_ls_independence();
        test_release_resume();
        test_simul_alloc_release();
        test_bubble_invalid_release();
        test_ls_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
